pipe_sched: RTL and testbench

Pipeline flush/halt sequencer for the RV32IM 5-stage core. Arbitrates redirect requests from Execute (branch mispredict) and Write-back (trap) and the external halt request. Drives the per-stage `pipe_flush` and the shared `cpu_halt` inputs of Fetch/Decode/Execute/Mem, and hands the corrected PC to Fetch over a valid/rdy handshake. It is the only source of those control signals in the core.

---
 rtl/cpu_params_pkg.sv | 27 ++
 rtl/pipe_sched_if.sv | 25 ++
 rtl/pipe_sched.sv | 116 +++++++++++
 tb/tb_pipe_sched.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_params_pkg.sv
// cpu_params_pkg: shared constants for the RV32IM 5-stage core.
// Contents:
//   - Stage indices for the per-stage control vectors.
//   - Flush masks used by the pipeline sequencer.
//   - State type of the pipeline flush/halt sequencer.
package cpu_params_pkg;

  // Bit positions in per-stage control vectors (e.g. flush_out)
  localparam int STG_FET = 0;
  localparam int STG_DEC = 1;
  localparam int STG_EXE = 2;
  localparam int STG_MEM = 3;

  // A mispredict resolves in Execute, so only the younger Fetch/Decode
  // contents are wrong. A trap retires from Write-back and kills everything.
  localparam logic [3:0] FLUSH_MIS  = 4'b0011;
  localparam logic [3:0] FLUSH_TRAP = 4'b1111;

  typedef enum logic [2:0] {
    PS_RUN      = 3'd0,
    PS_FLUSH    = 3'd1,
    PS_REDIRECT = 3'd2,
    PS_DRAIN    = 3'd3,
    PS_HALTED   = 3'd4
  } psched_state_t;

endpackage

// File: rtl/pipe_sched_if.sv
// pipe_sched_if: redirect handshake between the pipeline sequencer and Fetch.
// Signals:
//   redirect_valid_out  sequencer -> Fetch, corrected PC is valid
//   redirect_pc_out     sequencer -> Fetch, corrected PC
//   redirect_rdy_in     Fetch -> sequencer, PC accepted this cycle
// Modports: master (sequencer side), slave (Fetch side).
interface pipe_sched_if #(
  parameter int PC_SZ = 32
);
  logic             redirect_valid_out;
  logic [PC_SZ-1:0] redirect_pc_out;
  logic             redirect_rdy_in;

  modport master (
    output redirect_valid_out,
    output redirect_pc_out,
    input  redirect_rdy_in
  );

  modport slave (
    input  redirect_valid_out,
    input  redirect_pc_out,
    output redirect_rdy_in
  );
endinterface

// File: rtl/pipe_sched.sv
// pipe_sched: pipeline flush/halt sequencer.
// Arbitrates trap (Write-back) > mispredict (Execute) > halt request and
// drives the per-stage flush, the shared stall and the Fetch redirect.
// Ports:
//   clk_in, reset_in      clock, asynchronous active-low reset
//   mis_in, mis_pc_in     mispredict pulse and corrected PC
//   trap_in, trap_pc_in   trap pulse and trap vector PC
//   halt_req_in           level, debug halt request
//   resume_in             pulse, leave HALTED
//   pipe_empty_in         all stages empty
//   redir                 redirect handshake to Fetch (master modport)
//   flush_out             per-stage flush, bit0 Fetch .. bit3 Mem
//   cpu_halt_out          stall all stage inputs
//   halted_out            core halted and drained
//   flush_cnt_out         saturating count of flushes issued
// All outputs decode only registered state, so no input reaches an output
// combinationally.
module pipe_sched
  import cpu_params_pkg::*;
#(
  parameter int PC_SZ  = 32,
  parameter int CNT_SZ = 16
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic              mis_in,
  input  logic [PC_SZ-1:0]  mis_pc_in,
  input  logic              trap_in,
  input  logic [PC_SZ-1:0]  trap_pc_in,
  input  logic              halt_req_in,
  input  logic              resume_in,
  input  logic              pipe_empty_in,
  pipe_sched_if.master      redir,
  output logic [3:0]        flush_out,
  output logic              cpu_halt_out,
  output logic              halted_out,
  output logic [CNT_SZ-1:0] flush_cnt_out
);

  psched_state_t     state_reg, state_next;
  logic [PC_SZ-1:0]  pc_reg, pc_next;
  logic [3:0]        mask_reg, mask_next;
  logic [CNT_SZ-1:0] cnt_reg;
  logic              flush_event;

  always_ff @(posedge clk_in or negedge reset_in) begin
    if (!reset_in) begin
      state_reg <= PS_RUN;
      pc_reg    <= '0;
      mask_reg  <= '0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      mask_reg  <= mask_next;
      if (flush_event && (cnt_reg != {CNT_SZ{1'b1}}))
        cnt_reg <= cnt_reg + CNT_SZ'(1);
    end
  end

  always_comb begin
    state_next  = state_reg;
    pc_next     = pc_reg;
    mask_next   = mask_reg;
    flush_event = 1'b0;

    unique case (state_reg)
      PS_RUN, PS_DRAIN: begin
        if (trap_in) begin
          state_next  = PS_FLUSH;
          pc_next     = trap_pc_in;
          mask_next   = FLUSH_TRAP;
          flush_event = 1'b1;
        end else if (mis_in) begin
          state_next  = PS_FLUSH;
          pc_next     = mis_pc_in;
          mask_next   = FLUSH_MIS;
          flush_event = 1'b1;
        end else if (state_reg == PS_RUN) begin
          if (halt_req_in) state_next = PS_DRAIN;
        end else if (pipe_empty_in) begin
          state_next = PS_HALTED;
        end else if (!halt_req_in) begin
          state_next = PS_RUN;
        end
      end
      // Mispredicts are ignored once a redirect is in flight; only a trap
      // can override the pending PC.
      PS_FLUSH, PS_REDIRECT: begin
        if (trap_in) begin
          state_next  = PS_FLUSH;
          pc_next     = trap_pc_in;
          mask_next   = FLUSH_TRAP;
          flush_event = 1'b1;
        end else if (state_reg == PS_FLUSH) begin
          state_next = PS_REDIRECT;
        end else if (redir.redirect_rdy_in) begin
          // A halt requested meanwhile resumes draining after the redirect
          state_next = halt_req_in ? PS_DRAIN : PS_RUN;
        end
      end
      PS_HALTED: begin
        if (resume_in && !halt_req_in) state_next = PS_RUN;
      end
      default: state_next = PS_RUN;
    endcase
  end

  assign flush_out              = (state_reg == PS_FLUSH) ? mask_reg : 4'b0000;
  assign cpu_halt_out           = (state_reg != PS_RUN);
  assign halted_out             = (state_reg == PS_HALTED);
  assign redir.redirect_valid_out = (state_reg == PS_REDIRECT);
  assign redir.redirect_pc_out    = pc_reg;
  assign flush_cnt_out          = cnt_reg;

endmodule

// File: tb/tb_pipe_sched.sv
// tb_pipe_sched: self-checking bench for pipe_sched.
// Directed scenarios plus randomized traffic, each cycle compared against a
// behavioural model of the sequencer's documented rules.
module tb_pipe_sched;

  localparam int PC_SZ  = 32;
  localparam int CNT_SZ = 16;
  localparam int CNT_MAX = 65535;

  // Model modes
  localparam int M_RUN = 0, M_FLUSH = 1, M_REDIR = 2, M_DRAIN = 3, M_HALTED = 4;

  logic              clk_in = 1'b0;
  logic              reset_in = 1'b0;
  logic              mis_in = 1'b0;
  logic [PC_SZ-1:0]  mis_pc_in = '0;
  logic              trap_in = 1'b0;
  logic [PC_SZ-1:0]  trap_pc_in = '0;
  logic              halt_req_in = 1'b0;
  logic              resume_in = 1'b0;
  logic              pipe_empty_in = 1'b0;
  logic [3:0]        flush_out;
  logic              cpu_halt_out;
  logic              halted_out;
  logic [CNT_SZ-1:0] flush_cnt_out;

  pipe_sched_if #(.PC_SZ(PC_SZ)) redir_if ();

  pipe_sched #(.PC_SZ(PC_SZ), .CNT_SZ(CNT_SZ)) dut (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .mis_in        (mis_in),
    .mis_pc_in     (mis_pc_in),
    .trap_in       (trap_in),
    .trap_pc_in    (trap_pc_in),
    .halt_req_in   (halt_req_in),
    .resume_in     (resume_in),
    .pipe_empty_in (pipe_empty_in),
    .redir         (redir_if.master),
    .flush_out     (flush_out),
    .cpu_halt_out  (cpu_halt_out),
    .halted_out    (halted_out),
    .flush_cnt_out (flush_cnt_out)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  // Model state
  int          m_mode = M_RUN;
  logic [31:0] m_pc   = '0;
  logic [3:0]  m_mask = '0;
  int          m_cnt  = 0;

  bit watch_stale = 0;
  int stale_xfers = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_RUN; m_pc = '0; m_mask = '0; m_cnt = 0;
  endtask

  task automatic model_flush(input logic [31:0] pc, input logic [3:0] mask);
    m_mode = M_FLUSH; m_pc = pc; m_mask = mask;
    if (m_cnt < CNT_MAX) m_cnt++;
  endtask

  // Advances the model across the coming rising edge using current inputs
  task automatic model_step();
    bit takes_trap = (m_mode != M_HALTED);
    bit takes_mis  = (m_mode == M_RUN) || (m_mode == M_DRAIN);
    if (trap_in && takes_trap) model_flush(trap_pc_in, 4'hF);
    else if (mis_in && takes_mis) model_flush(mis_pc_in, 4'h3);
    else begin
      case (m_mode)
        M_RUN:    if (halt_req_in) m_mode = M_DRAIN;
        M_FLUSH:  m_mode = M_REDIR;
        M_REDIR:  if (redir_if.redirect_rdy_in) m_mode = halt_req_in ? M_DRAIN : M_RUN;
        M_DRAIN:  if (pipe_empty_in) m_mode = M_HALTED;
                  else if (!halt_req_in) m_mode = M_RUN;
        M_HALTED: if (resume_in && !halt_req_in) m_mode = M_RUN;
        default:  m_mode = M_RUN;
      endcase
    end
  endtask

  task automatic compare_all();
    check_eq("flush",    flush_out, (m_mode == M_FLUSH) ? m_mask : 4'h0);
    check_eq("cpu_halt", cpu_halt_out, m_mode != M_RUN);
    check_eq("halted",   halted_out, m_mode == M_HALTED);
    check_eq("valid",    redir_if.redirect_valid_out, m_mode == M_REDIR);
    if (m_mode == M_REDIR) check_eq("pc", redir_if.redirect_pc_out, m_pc);
    check_eq("cnt",      flush_cnt_out, m_cnt);
  endtask

  // Called at a falling edge: drive inputs, step model, compare at next fall
  task automatic cycle(input bit t, input logic [31:0] tpc, input bit m, input logic [31:0] mpc,
                       input bit h, input bit r, input bit e, input bit rdy);
    trap_in = t; trap_pc_in = tpc; mis_in = m; mis_pc_in = mpc;
    halt_req_in = h; resume_in = r; pipe_empty_in = e;
    redir_if.redirect_rdy_in = rdy;
    if (redir_if.redirect_valid_out && rdy && !t) begin
      $display("xfer pc=0x%08h cnt=%0d", redir_if.redirect_pc_out, flush_cnt_out);
      if (watch_stale && redir_if.redirect_pc_out == 32'h120) stale_xfers++;
    end
    model_step();
    @(negedge clk_in);
    compare_all();
  endtask

  task automatic idle(input bit rdy);
    cycle(0, 0, 0, 0, 0, 0, 0, rdy);
  endtask

  initial begin
    int cnt0;
    redir_if.redirect_rdy_in = 1'b0;
    reset_in = 1'b0;
    repeat (2) @(negedge clk_in);
    reset_in = 1'b1;
    model_reset();
    check_eq("rst_flush", flush_out, 4'h0);
    check_eq("rst_halt",  cpu_halt_out, 1'b0);
    check_eq("rst_valid", redir_if.redirect_valid_out, 1'b0);
    check_eq("rst_pc",    redir_if.redirect_pc_out, 32'h0);
    check_eq("rst_cnt",   flush_cnt_out, 16'h0);
    idle(1);

    // Mispredict
    cycle(0, 0, 1, 32'h120, 0, 0, 0, 1);
    check_eq("mis_flush", flush_out, 4'b0011);
    check_eq("mis_halt",  cpu_halt_out, 1'b1);
    idle(1);
    check_eq("mis_valid", redir_if.redirect_valid_out, 1'b1);
    check_eq("mis_pc",    redir_if.redirect_pc_out, 32'h120);
    idle(1);
    check_eq("mis_run_halt", cpu_halt_out, 1'b0);
    check_eq("mis_run_valid", redir_if.redirect_valid_out, 1'b0);

    // Trap beats mispredict
    cnt0 = m_cnt;
    cycle(1, 32'h4, 1, 32'h200, 0, 0, 0, 1);
    check_eq("tvm_flush", flush_out, 4'b1111);
    check_eq("tvm_cnt",   flush_cnt_out, cnt0 + 1);
    idle(1);
    check_eq("tvm_pc",    redir_if.redirect_pc_out, 32'h4);
    idle(1);

    // Trap during REDIRECT
    watch_stale = 1;
    cycle(0, 0, 1, 32'h120, 0, 0, 0, 0);
    repeat (3) idle(0);
    check_eq("tdr_pending", redir_if.redirect_pc_out, 32'h120);
    cycle(1, 32'h4, 0, 0, 0, 0, 0, 0);
    check_eq("tdr_flush", flush_out, 4'b1111);
    idle(1);
    check_eq("tdr_pc", redir_if.redirect_pc_out, 32'h4);
    idle(1);
    idle(1);
    watch_stale = 0;
    check_eq("tdr_no_stale", stale_xfers, 0);

    // Halt / drain / resume
    repeat (5) begin
      cycle(0, 0, 0, 0, 1, 0, 0, 0);
      check_eq("hlt_stall", cpu_halt_out, 1'b1);
    end
    cycle(0, 0, 0, 0, 1, 0, 1, 0);
    check_eq("hlt_halted", halted_out, 1'b1);
    cycle(0, 0, 0, 0, 1, 1, 1, 0);
    check_eq("hlt_resume_ign", halted_out, 1'b1);
    cycle(0, 0, 0, 0, 0, 0, 1, 0);
    check_eq("hlt_still", halted_out, 1'b1);
    cycle(0, 0, 0, 0, 0, 1, 1, 0);
    check_eq("hlt_resumed", halted_out, 1'b0);
    check_eq("hlt_run", cpu_halt_out, 1'b0);

    // Randomized traffic
    begin
      bit h = 0;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(19) == 0) h = ~h;
        cycle($urandom_range(15) == 0, $urandom, $urandom_range(7) == 0, $urandom,
              h, $urandom_range(7) == 0, $urandom_range(3) == 0, $urandom_range(1) == 1);
      end
    end
    repeat (3) cycle(0, 0, 0, 0, 0, 1, 0, 1);

    // Asynchronous reset while a redirect is pending
    cycle(0, 0, 1, 32'h120, 0, 0, 0, 0);
    idle(0);
    check_eq("rstr_valid_pre", redir_if.redirect_valid_out, 1'b1);
    #2 reset_in = 1'b0;
    #1;
    model_reset();
    check_eq("rstr_flush", flush_out, 4'h0);
    check_eq("rstr_halt",  cpu_halt_out, 1'b0);
    check_eq("rstr_valid", redir_if.redirect_valid_out, 1'b0);
    check_eq("rstr_pc",    redir_if.redirect_pc_out, 32'h0);
    check_eq("rstr_cnt",   flush_cnt_out, 16'h0);
    @(negedge clk_in);
    reset_in = 1'b1;
    idle(1);

    // Counter saturation: a held trap re-enters FLUSH every cycle
    repeat (CNT_MAX) cycle(1, 32'h8, 0, 0, 0, 0, 0, 0);
    check_eq("sat_max", flush_cnt_out, 16'hFFFF);
    cycle(1, 32'h8, 0, 0, 0, 0, 0, 0);
    check_eq("sat_hold", flush_cnt_out, 16'hFFFF);
    idle(1);
    idle(1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Absolute time limit so the bench always ends
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    n_errors++;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
